// File: rtl/rv32_pkg.sv
// Shared RV32I constants for the instruction encoder/writer: format codes,
// opcodes, the canonical NOP and the writer state encoding.
package rv32_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Bit 30 carries the SUB/SRA/SRAI selector; every other funct7 bit is zero.
  function automatic logic [6:0] makeFunct7(input logic subSra);
    makeFunct7 = {1'b0, subSra, 5'b0};
  endfunction

endpackage

// File: rtl/insn_encoder_writer_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and synchronous reset.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             doPush, doPop;

  assign doPush = push_i && !full_q;
  assign doPop  = pop_i && !empty_q;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    cnt_d   = cnt_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    if (doPush && !doPop)      cnt_d = cnt_q + 1'b1;
    else if (doPop && !doPush) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == DEPTH_CNT);
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: the pointers and flags decide what is valid.
  always_ff @(posedge clk_i) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/insn_encoder_writer.sv
// Packs decoded RV32I fields into instruction words, buffers them and writes
// them sequentially into instruction memory starting at BASE_ADDR.
module insn_encoder_writer
  import rv32_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rsa,
  input  logic [4:0]        rsb,
  input  logic [2:0]        func3,
  input  logic              sub_sra,
  input  logic [31:0]       imm,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              bad_fmt,
  output logic              ovf
);

  // Shift-immediates reuse the funct7 slot and keep only a 5-bit shamt.
  function automatic logic [31:0] encodeInsn(
    input logic [2:0]  f,
    input logic [6:0]  op,
    input logic [4:0]  rdIdx,
    input logic [4:0]  rsaIdx,
    input logic [4:0]  rsbIdx,
    input logic [2:0]  f3,
    input logic        subSra,
    input logic [31:0] immVal
  );
    logic [6:0]  f7;
    logic [31:0] word;
    f7 = makeFunct7(subSra);
    case (f)
      FMT_R: word = {f7, rsbIdx, rsaIdx, f3, rdIdx, op};
      FMT_I: begin
        if (op == OP_IMM && (f3 == 3'b001 || f3 == 3'b101))
          word = {f7, immVal[4:0], rsaIdx, f3, rdIdx, op};
        else
          word = {immVal[11:0], rsaIdx, f3, rdIdx, op};
      end
      FMT_S: word = {immVal[11:5], rsbIdx, rsaIdx, f3, immVal[4:0], op};
      FMT_B: word = {immVal[12], immVal[10:5], rsbIdx, rsaIdx, f3,
                     immVal[4:1], immVal[11], op};
      FMT_U: word = {immVal[31:12], rdIdx, op};
      FMT_J: word = {immVal[20], immVal[10:1], immVal[11], immVal[19:12],
                     rdIdx, op};
      default: word = NOP;
    endcase
    encodeInsn = word;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              badFmt_q;

  logic              fifoFull, fifoEmpty;
  logic [31:0]       fifoHead, encWord;
  logic              accept, illegalFmt, writeNow, writeAtMax;

  assign encWord    = encodeInsn(fmt, opcode, rd, rsa, rsb, func3, sub_sra, imm);
  assign illegalFmt = (fmt > FMT_J);
  assign in_ready   = !fifoFull && (state_q == ST_IDLE || state_q == ST_RUN)
                      && !ovf_q && !flush;
  assign accept     = in_valid && in_ready;
  assign writeNow   = !fifoEmpty && !mem_stall && !ovf_q;
  assign writeAtMax = writeNow && (addr_q == {ADDR_W{1'b1}});

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (accept),
    .pop_i   (writeNow),
    .wdata_i (encWord),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A write landing on the last address overrides every other transition.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ovf_d   = ovf_q;
    if (writeNow) addr_d = addr_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (flush && fifoEmpty) state_d = ST_DONE;
        else if (accept)        state_d = ST_RUN;
      end
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (fifoEmpty) state_d = ST_DONE;
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = BASE_ADDR;
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
    if (writeAtMax) begin
      state_d = ST_ERR;
      ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= BASE_ADDR;
      ovf_q    <= 1'b0;
      badFmt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      ovf_q    <= ovf_d;
      badFmt_q <= accept && illegalFmt;
    end
  end

  assign mem_we    = writeNow;
  assign mem_addr  = addr_q;
  assign mem_wdata = fifoEmpty ? 32'h0 : fifoHead;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign bad_fmt   = badFmt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_insn_encoder_writer.sv
// Scoreboard bench: stimulus pushes expected memory writes, negedge monitors
// pop and compare them; a second instance with ADDR_W=2 covers overflow.
module tb_insn_encoder_writer;
  import rv32_pkg::*;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rsa;
    logic [4:0]  rsb;
    logic [2:0]  f3;
    logic        ss;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst0, rst1;
  logic        inValid, flush, memStall, subSra;
  logic [2:0]  fmt, func3;
  logic [6:0]  opcode;
  logic [4:0]  rd, rsa, rsb;
  logic [31:0] imm;

  logic        inReady0, memWe0, busy0, done0, badFmt0, ovf0;
  logic [7:0]  memAddr0;
  logic [31:0] memWdata0;
  logic        inReady1, memWe1, busy1, done1, badFmt1, ovf1;
  logic [1:0]  memAddr1;
  logic [31:0] memWdata1;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        mon0, mon1;
  int          checks = 0;
  int          failures = 0;
  int          sel = 0;
  logic [7:0]  expAddr0 = 8'd0;
  logic [7:0]  expAddr1 = 8'd0;

  vec_t        immVecs [6];
  vec_t        bpVecs  [6];
  vec_t        luiVecs [5];
  vec_t        vR1, vR2, vBad;

  always #5 CLK = ~CLK;

  insn_encoder_writer #(.ADDR_W(8), .FIFO_DEPTH(4), .BASE_ADDR(8'd0)) dut0 (
    .CLK(CLK), .RST(rst0), .in_valid(inValid), .in_ready(inReady0),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rsa(rsa), .rsb(rsb),
    .func3(func3), .sub_sra(subSra), .imm(imm), .flush(flush),
    .mem_stall(memStall), .mem_we(memWe0), .mem_addr(memAddr0),
    .mem_wdata(memWdata0), .busy(busy0), .done(done0),
    .bad_fmt(badFmt0), .ovf(ovf0)
  );

  insn_encoder_writer #(.ADDR_W(2), .FIFO_DEPTH(4), .BASE_ADDR(2'd0)) dut1 (
    .CLK(CLK), .RST(rst1), .in_valid(inValid), .in_ready(inReady1),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rsa(rsa), .rsb(rsb),
    .func3(func3), .sub_sra(subSra), .imm(imm), .flush(flush),
    .mem_stall(memStall), .mem_we(memWe1), .mem_addr(memAddr1),
    .mem_wdata(memWdata1), .busy(busy1), .done(done1),
    .bad_fmt(badFmt1), .ovf(ovf1)
  );

  function automatic vec_t mkVec(input logic [2:0] f, input logic [6:0] op,
                                 input logic [4:0] d, input logic [4:0] a,
                                 input logic [4:0] b, input logic [2:0] f3,
                                 input logic s, input logic [31:0] im,
                                 input logic [31:0] w);
    vec_t v;
    v.fmt = f; v.op = op; v.rd = d; v.rsa = a; v.rsb = b;
    v.f3 = f3; v.ss = s; v.imm = im; v.word = w;
    return v;
  endfunction

  function automatic bit curReady();
    return (sel != 0) ? inReady1 : inReady0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic driveTuple(input vec_t v);
    fmt = v.fmt; opcode = v.op; rd = v.rd; rsa = v.rsa; rsb = v.rsb;
    func3 = v.f3; subSra = v.ss; imm = v.imm;
  endtask

  task automatic pushExpected(input logic [31:0] word);
    if (sel != 0) begin
      q1.push_back({expAddr1, word});
      expAddr1 = expAddr1 + 8'd1;
    end else begin
      q0.push_back({expAddr0, word});
      expAddr0 = expAddr0 + 8'd1;
    end
  endtask

  // Offers one tuple, waits (bounded) for acceptance, returns #1 after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit expectWrite);
    int waitCycles = 0;
    driveTuple(v);
    inValid = 1'b1;
    while (!curReady() && waitCycles < 50) begin
      @(posedge CLK); #1;
      waitCycles++;
    end
    if (!curReady()) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
      inValid = 1'b0;
      return;
    end
    if (expectWrite) pushExpected(v.word);
    @(posedge CLK); #1;
    inValid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (((sel != 0) ? q1.size() : q0.size()) != 0 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    @(posedge CLK); #1;
    checkOutput(name, (sel != 0) ? q1.size() : q0.size(), 0);
  endtask

  always @(negedge CLK) begin
    if (memWe0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("[TB] FAIL write0_unexpected actual addr=%0h data=%08h required no write",
                 memAddr0, memWdata0);
      end else begin
        mon0 = q0.pop_front();
        if (memAddr0 !== mon0.addr || memWdata0 !== mon0.data) begin
          failures++;
          $display("[TB] FAIL write0 actual addr=%0h data=%08h required addr=%0h data=%08h",
                   memAddr0, memWdata0, mon0.addr, mon0.data);
        end
      end
    end
    if (memWe1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("[TB] FAIL write1_unexpected actual addr=%0h data=%08h required no write",
                 memAddr1, memWdata1);
      end else begin
        mon1 = q1.pop_front();
        if ({6'b0, memAddr1} !== mon1.addr || memWdata1 !== mon1.data) begin
          failures++;
          $display("[TB] FAIL write1 actual addr=%0h data=%08h required addr=%0h data=%08h",
                   memAddr1, memWdata1, mon1.addr, mon1.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepted;
    int n;

    vR1  = mkVec(FMT_R, OP_REG, 5'd1, 5'd2, 5'd15, 3'd0, 1'b0, 32'h0, 32'h00F100B3);
    vR2  = mkVec(FMT_R, OP_REG, 5'd1, 5'd20, 5'd2, 3'd0, 1'b1, 32'h0, 32'h402A00B3);
    vBad = mkVec(3'd7, OP_REG, 5'd5, 5'd6, 5'd7, 3'd2, 1'b1, 32'hFFFF_FFFF, NOP);
    immVecs[0] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd9, 3'b000, 1'b0, 32'd5, 32'h00500093);
    immVecs[1] = mkVec(FMT_S, OP_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd8, 32'h0020A423);
    immVecs[2] = mkVec(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'hFFFF_FFFC, 32'hFE000EE3);
    immVecs[3] = mkVec(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 32'h008000EF);
    immVecs[4] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h12345000, 32'h123452B7);
    immVecs[5] = mkVec(FMT_I, OP_IMM, 5'd3, 5'd3, 5'd0, 3'b101, 1'b1, 32'h404, 32'h4041D193);
    bpVecs[0] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0, 32'h00000093);
    bpVecs[1] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1, 32'h00100093);
    bpVecs[2] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2, 32'h00200093);
    bpVecs[3] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd3, 32'h00300093);
    bpVecs[4] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4, 32'h00400093);
    bpVecs[5] = mkVec(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5, 32'h00500093);
    luiVecs[0] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00001000, 32'h000012B7);
    luiVecs[1] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00002000, 32'h000022B7);
    luiVecs[2] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00003000, 32'h000032B7);
    luiVecs[3] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00004000, 32'h000042B7);
    luiVecs[4] = mkVec(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00005000, 32'h000052B7);

    rst0 = 1'b1; rst1 = 1'b1;
    inValid = 1'b0; flush = 1'b0; memStall = 1'b0;
    driveTuple(vR1);
    repeat (2) @(posedge CLK);
    #1;
    rst0 = 1'b0;
    #1;

    // Reset state of the main instance.
    checkOutput("rst_in_ready", inReady0, 1);
    checkOutput("rst_mem_we", memWe0, 0);
    checkOutput("rst_mem_addr", memAddr0, 0);
    checkOutput("rst_mem_wdata", memWdata0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_done", done0, 0);
    checkOutput("rst_bad_fmt", badFmt0, 0);
    checkOutput("rst_ovf", ovf0, 0);

    // R-type pair, with first-write latency.
    applyStimulus(vR1, 1'b1);
    checkOutput("latency_we", memWe0, 1);
    checkOutput("latency_addr", memAddr0, 0);
    checkOutput("run_busy", busy0, 1);
    applyStimulus(vR2, 1'b1);
    waitIdle("rtype_drain");

    for (int i = 0; i < 6; i++) applyStimulus(immVecs[i], 1'b1);
    waitIdle("imm_drain");

    // Backpressure: stalled memory, six offers, four fit.
    memStall = 1'b1;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      driveTuple(bpVecs[i]);
      inValid = 1'b1;
      if (inReady0) begin
        accepted++;
        pushExpected(bpVecs[i].word);
      end
      @(posedge CLK); #1;
    end
    inValid = 1'b0;
    checkOutput("bp_accepts", accepted, 4);
    checkOutput("bp_ready_low", inReady0, 0);
    checkOutput("bp_no_write", memWe0, 0);
    memStall = 1'b0;
    waitIdle("bp_drain");
    checkOutput("bp_ready_high", inReady0, 1);

    // Flush with two queued words, then an illegal format at BASE_ADDR.
    memStall = 1'b1;
    applyStimulus(immVecs[0], 1'b1);
    applyStimulus(immVecs[5], 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_ready_low", inReady0, 0);
    @(posedge CLK); #1;
    flush = 1'b0;
    memStall = 1'b0;
    #1;
    checkOutput("drain_busy", busy0, 1);
    checkOutput("drain_ready_low", inReady0, 0);
    n = 0;
    while (n < 10) begin
      @(posedge CLK); #1;
      n++;
      if (done0) break;
    end
    checkOutput("done_seen", done0, 1);
    checkOutput("done_latency", n, 3);
    checkOutput("flush_writes", q0.size(), 0);
    expAddr0 = 8'd0;
    @(posedge CLK); #1;
    checkOutput("done_pulse_end", done0, 0);
    checkOutput("idle_not_busy", busy0, 0);
    applyStimulus(vBad, 1'b1);
    checkOutput("bad_fmt_pulse", badFmt0, 1);
    checkOutput("base_addr_after_done", memAddr0, 0);
    @(posedge CLK); #1;
    checkOutput("bad_fmt_end", badFmt0, 0);
    waitIdle("bad_drain");

    // Reset while stalled with three words queued.
    memStall = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(bpVecs[i], 1'b0);
    rst0 = 1'b1;
    @(posedge CLK); #1;
    rst0 = 1'b0;
    memStall = 1'b0;
    #1;
    checkOutput("rst_mid_we", memWe0, 0);
    checkOutput("rst_mid_ready", inReady0, 1);
    checkOutput("rst_mid_addr", memAddr0, 0);
    expAddr0 = 8'd0;
    applyStimulus(immVecs[4], 1'b1);
    waitIdle("rst_mid_drain");

    // Overflow on the 2-bit address instance.
    rst0 = 1'b1;
    sel = 1;
    rst1 = 1'b0;
    #1;
    checkOutput("ovf_rst_state", ovf1, 0);
    checkOutput("ovf_rst_ready", inReady1, 1);
    for (int i = 0; i < 5; i++) applyStimulus(luiVecs[i], i < 4);
    checkOutput("ovf_set", ovf1, 1);
    checkOutput("ovf_ready_low", inReady1, 0);
    checkOutput("ovf_no_write", memWe1, 0);
    checkOutput("ovf_wrap_addr", memAddr1, 0);
    repeat (4) @(posedge CLK);
    #1;
    checkOutput("ovf_sticky", ovf1, 1);
    checkOutput("ovf_held_no_write", memWe1, 0);
    checkOutput("ovf_not_busy", busy1, 0);
    checkOutput("ovf_writes", q1.size(), 0);
    rst1 = 1'b1;
    @(posedge CLK); #1;
    rst1 = 1'b0;
    #1;
    checkOutput("ovf_cleared", ovf1, 0);
    checkOutput("ovf_rst_ready_again", inReady1, 1);
    checkOutput("ovf_rst_addr", memAddr1, 0);
    checkOutput("ovf_rst_we", memWe1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/insn_encoder_writer.md
Name: insn_encoder_writer

Overview:
Instruction encoder and program writer, the inverse of the instruction decoders in Control_Unit.
- Accepts decoded instruction fields (format, opcode, register indices, func3, sub_sra, immediate) over a valid/ready handshake.
- Packs them into 32-bit RV32I words and buffers them in a small FIFO.
- Writes them sequentially into instruction memory from a base address.
- Used for test-program loading and for round-trip checks against the R/I/S/B/U/J decoders.

Parameters:
ADDR_W, 8, instruction-memory word-address width.
FIFO_DEPTH, 4, encoded-word buffer depth (power of 2, >= 2).
BASE_ADDR, 0, first word address written after reset or after a completed flush.

Ports:
CLK  in  1  clock, all state updates on rising edge.
RST  in  1  synchronous, active-high reset.
in_valid  in  1  field tuple present.
in_ready  out  1  block can accept a tuple this cycle.
fmt  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
opcode  in  7  opcode field.
rd, rsa, rsb  in  5 each  destination / source A / source B register indices.
func3  in  3  func3 field.
sub_sra  in  1  instruction bit 30 (SUB/SRA/SRAI select).
imm  in  32  immediate value, byte offset for B and J.
flush  in  1  stop accepting, drain FIFO, then complete.
mem_stall  in  1  memory cannot take a write this cycle.
mem_we  out  1  write strobe.
mem_addr  out  ADDR_W  write word address.
mem_wdata  out  32  encoded instruction.
busy  out  1  state is RUN or DRAIN.
done  out  1  one-cycle pulse after flush drain completes.
bad_fmt  out  1  one-cycle pulse when an illegal-format tuple is accepted.
ovf  out  1  sticky: address space exhausted.

Behaviour:
Reset values:
- All outputs 0 except in_ready=1.
- FIFO empty; address counter = BASE_ADDR; state = IDLE.
- RST mid-operation discards FIFO contents and any pending write.

Handshake and write path:
- Accept when in_valid && in_ready.
- in_ready = !fifo_full && state in {IDLE, RUN} && !ovf.
- in_ready uses the registered full flag; a pop in the same cycle does not raise it.
- Encoding is combinational at the FIFO input. The encoded word is pushed on the accepting edge.
- Write path: mem_we = !fifo_empty && !mem_stall && !ovf. mem_wdata = FIFO head; mem_addr = counter.
- On each write edge the FIFO pops and the counter increments.
- Latency into an empty FIFO: accept at edge k, mem_we high in the cycle after k, write completes at edge k+1.
- Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.

Encoding rules (funct7 = {1'b0, sub_sra, 5'b0}):
- R: {funct7, rsb, rsa, func3, rd, opcode}.
- I: {imm[11:0], rsa, func3, rd, opcode}. If opcode=0010011 and func3 is 001 or 101, bits [31:25] = funct7 and bits [24:20] = imm[4:0].
- S: {imm[11:5], rsb, rsa, func3, imm[4:0], opcode}.
- B: {imm[12], imm[10:5], rsb, rsa, func3, imm[4:1], imm[11], opcode}.
- U: {imm[31:12], rd, opcode}.
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- fmt 6 or 7: encode NOP 32'h00000013 and pulse bad_fmt for one cycle.
- Unused immediate bits are ignored.

State machine:
- IDLE: first accept -> RUN. flush with FIFO empty -> DONE.
- RUN: flush -> DRAIN. The flush cycle itself accepts no tuple.
- DRAIN: in_ready=0. FIFO empty -> DONE.
- DONE: done=1 for one cycle; counter reloads BASE_ADDR; -> IDLE.
- ERR: entered when a write lands at address 2^ADDR_W-1.
  - The counter wraps to 0 but no further write is issued.
  - ovf=1 is sticky, in_ready=0, and FIFO contents are held. Only RST exits ERR.
- flush in IDLE/RUN is sampled as a level. flush in DRAIN, DONE or ERR is ignored.

Decomposition:
- Shared package rv32_pkg holds:
  - FMT_R..FMT_J constants and the opcode constants (OP_REG=0110011, OP_IMM=0010011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111, OP_JAL=1101111).
  - The NOP constant and the state encoding.
- One sub-module, sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH), with full/empty flags and synchronous reset.
- The encoder is a combinational function inside the top module.

Test Plan:
- R add: fmt=0, op=0110011, rd=1, rsa=2, rsb=15, func3=0, sub_sra=0 -> mem_wdata=00F100B3 at addr 0, mem_we one cycle after accept. Same with rsa=20, rsb=2, sub_sra=1 -> 402A00B3 at addr 1.
- Immediates, each decoded back through the matching decoder:
  - addi x1,x0,5 -> 00500093.
  - sw x2,8(x1) -> 0020A423.
  - beq x0,x0,imm=-4 -> FE000EE3.
  - jal x1,imm=8 -> 008000EF.
  - lui x5,imm=0x12345000 -> 123452B7.
  - srai x3,x3,4 (func3=101, sub_sra=1) -> 4041D193.
- Backpressure: hold mem_stall=1 and offer 6 tuples -> in_ready drops after 4 accepts. Release -> 4 writes at addr 0..3 in order, then in_ready=1.
- Flush: push 2 words, assert flush -> in_ready=0, 2 writes, done pulses one cycle later, next accept writes at BASE_ADDR. fmt=7 -> 00000013 written, bad_fmt pulse.
- Overflow with ADDR_W=2: 5 tuples -> writes at 0..3, ovf=1 sticky, 5th word stays in FIFO, no mem_we. RST -> ovf=0, addr 0.
- RST with mem_stall=1 and 3 words queued -> next cycle mem_we=0, in_ready=1; a new tuple writes at addr 0.
